// File: rtl/poly_addsub_ctrl_if.sv
// Bus between the polynomial add/sub controller, its sequencer and the coefficient RAMs.
// The slave side is the controller; the master side is whatever drives start/mode and
// hosts the RAMs.
interface poly_addsub_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 12
);
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] din_a;
  logic [DW-1:0] din_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] dout;

  modport master (
    output start, mode, din_a, din_b,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, dout
  );

  modport slave (
    input  start, mode, din_a, din_b,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, dout
  );
endinterface

// File: rtl/poly_addsub_ctrl.sv
// Polynomial add/sub controller: streams a[i], b[i] from the source RAMs, computes
// c[i] = (a[i] +/- b[i]) mod Q through one modular adder and writes c[i] to the
// result RAM. One coefficient per cycle, N coefficients per operation.

// Modular adder: a + b with a single conditional subtract of Q.
// Operands must already be reduced (< Q) for the result to land in [0, Q-1].
module mod_add #(
  parameter int DW = 12,
  parameter int Q  = 3329
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  localparam logic [DW:0] QW = (DW+1)'(Q);
  logic [DW:0] sum;
  logic [DW:0] red;

  // Carry-preserving sum, then fold back into range if it reached Q
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    red = sum - QW;
    y   = (sum >= QW) ? red[DW-1:0] : sum[DW-1:0];
  end
endmodule

module poly_addsub_ctrl #(
  parameter int N      = 256,
  parameter int AW     = 8,
  parameter int DW     = 12,
  parameter int Q      = 3329,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  poly_addsub_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(N-1);
  localparam logic [DW-1:0] QV   = DW'(Q);

  state_t        state, state_d;
  logic          busy, busy_d;
  logic          done, done_d;
  logic          rd_en, rd_en_d;
  logic [AW-1:0] rd_addr, rd_addr_d;
  logic          mode_q, mode_d;

  // Read-return pipeline: stage i holds the read issued i+1 cycles ago.
  // The last stage lines up with din_a/din_b arriving from the RAMs.
  logic [RD_LAT-1:0]         vld_pipe;
  logic [RD_LAT-1:0][AW-1:0] addr_pipe;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] dout;
  logic [DW-1:0] b_op;
  logic [DW-1:0] sum;

  // Subtraction reuses the adder by feeding Q-b; b==0 maps to 0 so the
  // operand stays below Q and the adder's single fold is enough.
  assign b_op = !mode_q ? bus.din_b
              : (bus.din_b == '0) ? '0 : QV - bus.din_b;

  mod_add #(.DW(DW), .Q(Q)) u_add (
    .a (bus.din_a),
    .b (b_op),
    .y (sum)
  );

  // Next-state and next-output decode; outputs are registered below
  always_comb begin
    state_d   = state;
    busy_d    = busy;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr;
    mode_d    = mode_q;
    case (state)
      IDLE: begin
        busy_d    = 1'b0;
        rd_addr_d = '0;
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          mode_d  = bus.mode;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (rd_addr == LAST) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr + 1'b1;
        end
      end
      DRAIN: begin
        // Leave once the final write is on the bus
        if (wr_en && wr_addr == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        rd_addr_d = '0;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        rd_addr_d = '0;
      end
    endcase
  end

  // FSM state and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
      mode_q  <= mode_d;
    end
  end

  // Valid/address shift register; its tail becomes the result-RAM write
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      dout      <= '0;
    end else begin
      vld_pipe[0]  <= rd_en;
      addr_pipe[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      wr_en   <= vld_pipe[RD_LAT-1];
      wr_addr <= addr_pipe[RD_LAT-1];
      if (vld_pipe[RD_LAT-1]) dout <= sum;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.dout    = dout;
endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// Bench for poly_addsub_ctrl: one instance with RD_LAT=1 (index 0), one with RD_LAT=2
// (index 1), each backed by behavioural source RAMs and a write log.
module tb_poly_addsub_ctrl;
  localparam int N = 256;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  poly_addsub_ctrl_if #(.AW(8), .DW(12)) if1 ();
  poly_addsub_ctrl_if #(.AW(8), .DW(12)) if2 ();

  poly_addsub_ctrl #(.N(N), .AW(8), .DW(12), .Q(Q), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));
  poly_addsub_ctrl #(.N(N), .AW(8), .DW(12), .Q(Q), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave));

  logic st [2];
  logic md [2];
  assign if1.start = st[0];
  assign if1.mode  = md[0];
  assign if2.start = st[1];
  assign if2.mode  = md[1];

  logic [11:0] ma [2][N];
  logic [11:0] mb [2][N];

  // Source RAMs: one read stage for dut1, two for dut2
  logic [11:0] r1a, r1b, p2a, p2b, q2a, q2b;
  always @(posedge clk) begin
    if (if1.rd_en) begin
      r1a <= ma[0][if1.rd_addr];
      r1b <= mb[0][if1.rd_addr];
    end
    if (if2.rd_en) begin
      p2a <= ma[1][if2.rd_addr];
      p2b <= mb[1][if2.rd_addr];
    end
    q2a <= p2a;
    q2b <= p2b;
  end
  assign if1.din_a = r1a;
  assign if1.din_b = r1b;
  assign if2.din_a = q2a;
  assign if2.din_b = q2b;

  logic done_s [2], busy_s [2], rden_s [2], wren_s [2];
  int   rdaddr_s [2];
  assign done_s[0] = if1.done;   assign done_s[1] = if2.done;
  assign busy_s[0] = if1.busy;   assign busy_s[1] = if2.busy;
  assign rden_s[0] = if1.rd_en;  assign rden_s[1] = if2.rd_en;
  assign wren_s[0] = if1.wr_en;  assign wren_s[1] = if2.wr_en;
  assign rdaddr_s[0] = int'(if1.rd_addr);
  assign rdaddr_s[1] = int'(if2.rd_addr);

  typedef struct { int addr; int data; } wr_t;
  wr_t wq [2][$];

  // Result-RAM write log, sampled mid-cycle
  always @(negedge clk) begin
    if (if1.wr_en) wq[0].push_back('{int'(if1.wr_addr), int'(if1.dout)});
    if (if2.wr_en) wq[1].push_back('{int'(if2.wr_addr), int'(if2.dout)});
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int ref_c(int a, int b, bit m);
    return m ? (a - b + Q) % Q : (a + b) % Q;
  endfunction

  task automatic fill_rand(input int d);
    for (int i = 0; i < N; i++) begin
      ma[d][i] = 12'($urandom_range(Q-1, 0));
      mb[d][i] = 12'($urandom_range(Q-1, 0));
    end
  endtask

  // Pulse (or hold) start at a negedge, scramble mode afterwards, wait for done.
  // Returns at the negedge of the done cycle; lat counts cycles from the start cycle.
  task automatic launch(input int d, input bit m, input bit hold, output int lat,
                        output bit b1, output bit r1, output int a1, output bit bd);
    wq[d].delete();
    md[d] = m;
    st[d] = 1'b1;
    @(negedge clk);
    if (!hold) st[d] = 1'b0;
    md[d] = ~m;
    lat = 1;
    b1 = busy_s[d];
    r1 = rden_s[d];
    a1 = rdaddr_s[d];
    while (!done_s[d] && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    st[d] = 1'b0;
    bd = busy_s[d];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    st[0] = 1'b0; st[1] = 1'b0; md[0] = 1'b0; md[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({if1.busy, if1.done, if1.rd_en, if1.wr_en} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b expected 0000", {if1.busy, if1.done, if1.rd_en, if1.wr_en}); end
    n_cmp++; if ({if1.rd_addr, if1.wr_addr, if1.dout} !== 28'd0) begin
      n_bad++; $display("FAIL reset_bus got %h expected 0", {if1.rd_addr, if1.wr_addr, if1.dout}); end
    n_cmp++; if ({if2.busy, if2.done, if2.rd_en, if2.wr_en, if2.dout} !== 16'd0) begin
      n_bad++; $display("FAIL reset_dut2 got %h expected 0", {if2.busy, if2.done, if2.rd_en, if2.wr_en, if2.dout}); end
    // start coinciding with reset must be dropped
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({if1.busy, if1.rd_en} !== 2'b00) begin
      n_bad++; $display("FAIL reset_start_drop got %b expected 00", {if1.busy, if1.rd_en}); end
  endtask

  task automatic test_add_ramp();
    int lat, a1, bad; bit b1, r1, bd;
    for (int i = 0; i < N; i++) begin
      ma[0][i] = 12'(i);
      mb[0][i] = 12'(2*i);
    end
    launch(0, 1'b0, 1'b0, lat, b1, r1, a1, bd);
    n_cmp++; if (lat !== N+3) begin n_bad++; $display("FAIL t1_latency got %0d expected %0d", lat, N+3); end
    n_cmp++; if ({b1, r1} !== 2'b11) begin n_bad++; $display("FAIL t1_first_read busy/rd_en got %b expected 11", {b1, r1}); end
    n_cmp++; if (a1 !== 0) begin n_bad++; $display("FAIL t1_first_addr got %0d expected 0", a1); end
    n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL t1_busy_in_done got %0d expected 0", bd); end
    n_cmp++; if (wq[0].size() !== N) begin n_bad++; $display("FAIL t1_write_count got %0d expected %0d", wq[0].size(), N); end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== (3*i) % Q) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t1_data bad entries got %0d expected 0", bad); end
    @(negedge clk);
    n_cmp++; if (done_s[0] !== 1'b0) begin n_bad++; $display("FAIL t1_done_width got %0d expected 0", done_s[0]); end
    n_cmp++; if (rdaddr_s[0] !== 0) begin n_bad++; $display("FAIL t1_rdaddr_idle got %0d expected 0", rdaddr_s[0]); end
  endtask

  task automatic test_edges();
    int lat, a1, bad; bit b1, r1, bd;
    // addition corners
    fill_rand(0);
    ma[0][0] = 12'd3328; mb[0][0] = 12'd1;
    ma[0][1] = 12'd3328; mb[0][1] = 12'd3328;
    ma[0][2] = 12'd0;    mb[0][2] = 12'd0;
    launch(0, 1'b0, 1'b0, lat, b1, r1, a1, bd);
    n_cmp++; if (wq[0].size() !== N) begin n_bad++; $display("FAIL t2_write_count got %0d expected %0d", wq[0].size(), N); end
    else begin
      n_cmp++; if (wq[0][0].data !== 0) begin n_bad++; $display("FAIL t2_3328p1 got %0d expected 0", wq[0][0].data); end
      n_cmp++; if (wq[0][1].data !== 3327) begin n_bad++; $display("FAIL t2_3328p3328 got %0d expected 3327", wq[0][1].data); end
      n_cmp++; if (wq[0][2].data !== 0) begin n_bad++; $display("FAIL t2_0p0 got %0d expected 0", wq[0][2].data); end
    end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== ref_c(ma[0][i], mb[0][i], 1'b0)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t2_data bad entries got %0d expected 0", bad); end
    repeat (2) @(negedge clk);
    // subtraction corners
    fill_rand(0);
    ma[0][0] = 12'd0;    mb[0][0] = 12'd1;
    ma[0][1] = 12'd5;    mb[0][1] = 12'd0;
    ma[0][2] = 12'd1664; mb[0][2] = 12'd1665;
    ma[0][3] = 12'd3328; mb[0][3] = 12'd3328;
    launch(0, 1'b1, 1'b0, lat, b1, r1, a1, bd);
    n_cmp++; if (wq[0].size() !== N) begin n_bad++; $display("FAIL t3_write_count got %0d expected %0d", wq[0].size(), N); end
    else begin
      n_cmp++; if (wq[0][0].data !== 3328) begin n_bad++; $display("FAIL t3_0m1 got %0d expected 3328", wq[0][0].data); end
      n_cmp++; if (wq[0][1].data !== 5) begin n_bad++; $display("FAIL t3_5m0 got %0d expected 5", wq[0][1].data); end
      n_cmp++; if (wq[0][2].data !== 3328) begin n_bad++; $display("FAIL t3_1664m1665 got %0d expected 3328", wq[0][2].data); end
      n_cmp++; if (wq[0][3].data !== 0) begin n_bad++; $display("FAIL t3_3328m3328 got %0d expected 0", wq[0][3].data); end
    end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== ref_c(ma[0][i], mb[0][i], 1'b1)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t3_data bad entries got %0d expected 0", bad); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, a1, bad; bit b1, r1, bd, m;
    fill_rand(0);
    m = 1'($urandom_range(1, 0));
    // start held high for the whole run: only the first is taken
    launch(0, m, 1'b1, lat, b1, r1, a1, bd);
    n_cmp++; if (lat !== N+3) begin n_bad++; $display("FAIL t4_hold_latency got %0d expected %0d", lat, N+3); end
    n_cmp++; if (wq[0].size() !== N) begin n_bad++; $display("FAIL t4_hold_writes got %0d expected %0d", wq[0].size(), N); end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== ref_c(ma[0][i], mb[0][i], m)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t4_hold_data bad entries got %0d expected 0", bad); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy_s[0], rden_s[0], wren_s[0]} !== 3'b000) begin
      n_bad++; $display("FAIL t4_no_queue got %b expected 000", {busy_s[0], rden_s[0], wren_s[0]}); end
    // start in the first idle cycle after done
    launch(0, ~m, 1'b0, lat, b1, r1, a1, bd);
    @(negedge clk);
    fill_rand(0);
    launch(0, m, 1'b0, lat, b1, r1, a1, bd);
    n_cmp++; if (lat !== N+3) begin n_bad++; $display("FAIL t4_b2b_latency got %0d expected %0d", lat, N+3); end
    n_cmp++; if (wq[0].size() !== N) begin n_bad++; $display("FAIL t4_b2b_writes got %0d expected %0d", wq[0].size(), N); end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== ref_c(ma[0][i], mb[0][i], m)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t4_b2b_data bad entries got %0d expected 0", bad); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int lat, a1, bad, seen; bit b1, r1, bd;
    fill_rand(0);
    wq[0].delete();
    md[0] = 1'b0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({wren_s[0], rden_s[0], busy_s[0]} !== 3'b000) begin
      n_bad++; $display("FAIL t5_after_reset wr/rd/busy got %b expected 000", {wren_s[0], rden_s[0], busy_s[0]}); end
    n_cmp++; if (rdaddr_s[0] !== 0) begin n_bad++; $display("FAIL t5_rdaddr got %0d expected 0", rdaddr_s[0]); end
    n_cmp++; if (wq[0].size() !== 98) begin n_bad++; $display("FAIL t5_partial_writes got %0d expected 98", wq[0].size()); end
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_s[0]) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL t5_no_done got %0d expected 0", seen); end
    n_cmp++; if (wq[0].size() !== 98) begin n_bad++; $display("FAIL t5_no_more_writes got %0d expected 98", wq[0].size()); end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== ref_c(ma[0][i], mb[0][i], 1'b0)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t5_partial_data bad entries got %0d expected 0", bad); end
    launch(0, 1'b1, 1'b0, lat, b1, r1, a1, bd);
    n_cmp++; if (lat !== N+3) begin n_bad++; $display("FAIL t5_restart_latency got %0d expected %0d", lat, N+3); end
    bad = 0;
    for (int i = 0; i < wq[0].size(); i++)
      if (wq[0][i].addr !== i || wq[0][i].data !== ref_c(ma[0][i], mb[0][i], 1'b1)) bad++;
    n_cmp++; if (bad !== 0 || wq[0].size() !== N) begin
      n_bad++; $display("FAIL t5_restart bad entries %0d writes %0d expected 0 and %0d", bad, wq[0].size(), N); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lat2();
    int lat, a1, bad; bit b1, r1, bd;
    for (int m = 0; m < 2; m++) begin
      fill_rand(1);
      ma[1][N-1] = 12'd3328; mb[1][N-1] = 12'(m ? 0 : 3328);
      launch(1, 1'(m), 1'b0, lat, b1, r1, a1, bd);
      n_cmp++; if (lat !== N+4) begin n_bad++; $display("FAIL t6_latency mode %0d got %0d expected %0d", m, lat, N+4); end
      n_cmp++; if (wq[1].size() !== N) begin n_bad++; $display("FAIL t6_writes mode %0d got %0d expected %0d", m, wq[1].size(), N); end
      bad = 0;
      for (int i = 0; i < wq[1].size(); i++)
        if (wq[1][i].addr !== i || wq[1][i].data !== ref_c(ma[1][i], mb[1][i], 1'(m))) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t6_data mode %0d bad entries got %0d expected 0", m, bad); end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_ramp();
    test_edges();
    test_back_to_back();
    test_mid_reset();
    test_lat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "timeout");
  end
endmodule
